// File: rtl/tdc_core.sv
// tdc_core: coarse/fine time-to-digital converter for the 4x4 SPAD pixel.
// Captures up to three photon timestamps per window and streams them out.
module tdc_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] DLL_Phase,
   input  logic        TDC_start,
   input  logic        TDC_trigger,
   input  logic        TDC_tgate,
   input  logic [15:0] TDC_spaden,
   input  logic [14:0] TDC_Range,
   output logic [14:0] TDC_Odata,
   output logic [4:0]  TDC_Oint,
   output logic [1:0]  TDC_Onum,
   output logic        TDC_Olast,
   output logic        TDC_Ovalid,
   input  logic        TDC_Oready,
   output logic        TDC_INT,
   output logic        rst_auto
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      DRAIN
   } state_t;

   localparam logic [19:0] EMPTY_BEAT = {15'h7FFF, 5'd0};

   state_t      state;
   logic        start_q;
   logic        trig_q;
   logic        ra_pend;
   logic [14:0] cnt;
   logic [1:0]  nhit;
   logic [1:0]  nhit_nx;
   logic [1:0]  rd_idx;
   logic [1:0]  nxt_idx;
   logic [19:0] hbuf [0:2];
   logic [31:0] ph_rot;
   logic [31:0] ph_edge;
   logic [4:0]  fine;
   logic [4:0]  pcnt;
   logic        start_edge;
   logic        cap;
   logic [19:0] cap_word;
   logic [19:0] first_word;

   // Fine code: lowest rising transition in the DLL phase ring.
   always_comb begin
      ph_rot  = {DLL_Phase[30:0], DLL_Phase[31]};
      ph_edge = DLL_Phase & ~ph_rot;
      fine    = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (ph_edge[i]) fine = 5'(i);
      end
   end

   // Intensity: number of enabled/fired SPADs.
   always_comb begin
      pcnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         pcnt = pcnt + {4'd0, TDC_spaden[i]};
      end
   end

   // Capture qualification and the word the first beat will carry.
   always_comb begin
      start_edge = TDC_start & ~start_q;
      cap        = (state == ARMED) && TDC_trigger && !trig_q &&
                   TDC_tgate && !rst_auto && (nhit != 2'd3);
      cap_word   = {cnt[9:0], fine, pcnt};
      nhit_nx    = nhit + {1'b0, cap};
      nxt_idx    = rd_idx + 2'd1;
      if (nhit != 2'd0)
         first_word = hbuf[0];
      else if (cap)
         first_word = cap_word;
      else
         first_word = EMPTY_BEAT;
   end

   // Edge detect registers and the two-cycle SPAD re-arm pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q  <= 1'b0;
         trig_q   <= 1'b0;
         ra_pend  <= 1'b0;
         rst_auto <= 1'b0;
      end else begin
         start_q  <= TDC_start;
         trig_q   <= TDC_trigger;
         ra_pend  <= cap;
         rst_auto <= cap | ra_pend;
      end
   end

   // Measurement FSM, hit buffer and registered stream outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 15'd0;
         nhit       <= 2'd0;
         rd_idx     <= 2'd0;
         hbuf[0]    <= 20'd0;
         hbuf[1]    <= 20'd0;
         hbuf[2]    <= 20'd0;
         TDC_Odata  <= 15'd0;
         TDC_Oint   <= 5'd0;
         TDC_Onum   <= 2'd0;
         TDC_Olast  <= 1'b0;
         TDC_Ovalid <= 1'b0;
         TDC_INT    <= 1'b0;
      end else begin
         TDC_INT <= 1'b0;
         if (cap) hbuf[nhit] <= cap_word;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  state <= ARMED;
                  cnt   <= 15'd0;
                  nhit  <= 2'd0;
               end
            end
            ARMED: begin
               nhit <= nhit_nx;
               if (cnt == TDC_Range) begin
                  state                  <= DRAIN;
                  rd_idx                 <= 2'd0;
                  TDC_Ovalid             <= 1'b1;
                  {TDC_Odata, TDC_Oint}  <= first_word;
                  TDC_Onum               <= nhit_nx;
                  TDC_Olast              <= (nhit_nx <= 2'd1);
               end else begin
                  cnt <= cnt + 15'd1;
               end
            end
            DRAIN: begin
               if (TDC_Ovalid && TDC_Oready) begin
                  if (TDC_Olast) begin
                     state      <= IDLE;
                     TDC_Ovalid <= 1'b0;
                     TDC_INT    <= 1'b1;
                     TDC_Odata  <= 15'd0;
                     TDC_Oint   <= 5'd0;
                     TDC_Onum   <= 2'd0;
                     TDC_Olast  <= 1'b0;
                  end else begin
                     rd_idx                <= nxt_idx;
                     {TDC_Odata, TDC_Oint} <= hbuf[nxt_idx];
                     TDC_Olast             <= ((nxt_idx + 2'd1) == nhit);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_core.sv
// tb_tdc_core: randomized and directed bench for tdc_core.
// Expected packets come from a window-level photon model.
module tb_tdc_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] DLL_Phase;
   logic        TDC_start;
   logic        TDC_trigger;
   logic        TDC_tgate;
   logic [15:0] TDC_spaden;
   logic [14:0] TDC_Range;
   logic [14:0] TDC_Odata;
   logic [4:0]  TDC_Oint;
   logic [1:0]  TDC_Onum;
   logic        TDC_Olast;
   logic        TDC_Ovalid;
   logic        TDC_Oready;
   logic        TDC_INT;
   logic        rst_auto;

   int total = 0;
   int bad   = 0;

   bit          trg  [0:2047];
   bit          gate [0:2047];
   logic [31:0] ph   [0:2047];
   logic [15:0] sp   [0:2047];

   logic [14:0] obs_d0;
   logic [4:0]  obs_i0;
   logic [1:0]  obs_n0;
   logic        obs_l0;
   int          obs_beats;

   tdc_core dut (
      .clk        (clk),
      .rst        (rst),
      .DLL_Phase  (DLL_Phase),
      .TDC_start  (TDC_start),
      .TDC_trigger(TDC_trigger),
      .TDC_tgate  (TDC_tgate),
      .TDC_spaden (TDC_spaden),
      .TDC_Range  (TDC_Range),
      .TDC_Odata  (TDC_Odata),
      .TDC_Oint   (TDC_Oint),
      .TDC_Onum   (TDC_Onum),
      .TDC_Olast  (TDC_Olast),
      .TDC_Ovalid (TDC_Ovalid),
      .TDC_Oready (TDC_Oready),
      .TDC_INT    (TDC_INT),
      .rst_auto   (rst_auto)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] fine_ref(input logic [31:0] p);
      for (int i = 0; i < 32; i++) begin
         if (p[i] && !p[(i + 31) % 32]) return 5'(i);
      end
      return 5'd0;
   endfunction

   task automatic clear_stim();
      for (int j = 0; j < 2048; j++) begin
         trg[j]  = 1'b0;
         gate[j] = 1'b1;
         ph[j]   = $urandom;
         sp[j]   = 16'($urandom);
      end
   endtask

   // One full measurement: model, window drive, drain with ready pattern.
   task automatic run_meas(input int R, input int mode, input string tag);
      logic [14:0] ed [0:2];
      logic [4:0]  ei [0:2];
      int          capj [0:2];
      int          en;
      int          last;
      int          nb;
      int          b;
      bit          prev;
      bit          done;
      bit          hs;
      bit          rdy;
      bit          ra;
      logic [14:0] xd;
      logic [4:0]  xi;
      logic [1:0]  xn;
      logic        xl;
      en   = 0;
      last = -100;
      prev = 1'b0;
      for (int j = 0; j <= R; j++) begin
         if (trg[j] && !prev && gate[j] && en < 3 && j > last + 2) begin
            ed[en]   = {10'(j % 1024), fine_ref(ph[j])};
            ei[en]   = 5'($countones(sp[j]));
            capj[en] = j;
            last     = j;
            en++;
         end
         prev = trg[j];
      end
      rst         = 1'b0;
      TDC_start   = 1'b0;
      TDC_Oready  = 1'b0;
      TDC_tgate   = 1'b1;
      TDC_trigger = 1'($urandom);
      TDC_Range   = 15'(R);
      tick();
      TDC_trigger = 1'b0;
      TDC_start   = 1'b1;
      tick();
      for (int j = 0; j <= R; j++) begin
         ra = 1'b0;
         for (int m = 0; m < en; m++)
            if (j == capj[m] + 1 || j == capj[m] + 2) ra = 1'b1;
         total++;
         if (rst_auto !== ra) begin
            bad++;
            $display("FAIL %s rst_auto cnt=%0d: got %b want %b",
                     tag, j, rst_auto, ra);
         end
         total++;
         if (TDC_Ovalid !== 1'b0 || TDC_INT !== 1'b0) begin
            bad++;
            $display("FAIL %s window_idle cnt=%0d: got valid=%b int=%b want 0 0",
                     tag, j, TDC_Ovalid, TDC_INT);
         end
         TDC_trigger = trg[j];
         TDC_tgate   = gate[j];
         DLL_Phase   = ph[j];
         TDC_spaden  = sp[j];
         TDC_start   = 1'($urandom);
         TDC_Oready  = 1'($urandom);
         tick();
      end
      nb   = (en == 0) ? 1 : en;
      b    = 0;
      done = 1'b0;
      for (int d = 0; d < 400 && !done; d++) begin
         ra = 1'b0;
         for (int m = 0; m < en; m++)
            if (R + 1 + d == capj[m] + 1 || R + 1 + d == capj[m] + 2) ra = 1'b1;
         total++;
         if (rst_auto !== ra) begin
            bad++;
            $display("FAIL %s rst_auto drain%0d: got %b want %b",
                     tag, d, rst_auto, ra);
         end
         xd = (en == 0) ? 15'h7FFF : ed[b];
         xi = (en == 0) ? 5'd0 : ei[b];
         xn = 2'(en);
         xl = (b == nb - 1);
         total++;
         if ({TDC_Ovalid, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_INT} !==
             {1'b1, xd, xi, xn, xl, 1'b0}) begin
            bad++;
            $display("FAIL %s beat%0d: got v=%b d=%h i=%0d n=%0d l=%b int=%b want v=1 d=%h i=%0d n=%0d l=%b int=0",
                     tag, b, TDC_Ovalid, TDC_Odata, TDC_Oint, TDC_Onum,
                     TDC_Olast, TDC_INT, xd, xi, xn, xl);
         end
         if (b == 0) begin
            obs_d0 = TDC_Odata;
            obs_i0 = TDC_Oint;
            obs_n0 = TDC_Onum;
            obs_l0 = TDC_Olast;
         end
         if (mode == 0)      rdy = 1'b1;
         else if (mode == 1) rdy = 1'($urandom);
         else                rdy = (d >= 5);
         TDC_Oready  = rdy;
         TDC_trigger = 1'($urandom);
         TDC_start   = 1'($urandom);
         hs = rdy && TDC_Ovalid;
         tick();
         if (hs) begin
            b++;
            if (b == nb) done = 1'b1;
         end
      end
      obs_beats = b;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s drain_timeout: got %0d beats want %0d", tag, b, nb);
      end
      total++;
      if (TDC_Ovalid !== 1'b0 || TDC_INT !== 1'b1) begin
         bad++;
         $display("FAIL %s int_pulse: got valid=%b int=%b want 0 1",
                  tag, TDC_Ovalid, TDC_INT);
      end
      TDC_start   = 1'b0;
      TDC_Oready  = 1'b0;
      TDC_trigger = 1'b0;
      tick();
      total++;
      if (TDC_INT !== 1'b0) begin
         bad++;
         $display("FAIL %s int_width: got %b want 0", tag, TDC_INT);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (TDC_Odata !== 15'd0) begin
         bad++; $display("FAIL reset Odata: got %h want 0", TDC_Odata);
      end
      total++;
      if (TDC_Oint !== 5'd0) begin
         bad++; $display("FAIL reset Oint: got %0d want 0", TDC_Oint);
      end
      total++;
      if (TDC_Onum !== 2'd0) begin
         bad++; $display("FAIL reset Onum: got %0d want 0", TDC_Onum);
      end
      total++;
      if (TDC_Olast !== 1'b0) begin
         bad++; $display("FAIL reset Olast: got %b want 0", TDC_Olast);
      end
      total++;
      if (TDC_Ovalid !== 1'b0) begin
         bad++; $display("FAIL reset Ovalid: got %b want 0", TDC_Ovalid);
      end
      total++;
      if (TDC_INT !== 1'b0) begin
         bad++; $display("FAIL reset INT: got %b want 0", TDC_INT);
      end
      total++;
      if (rst_auto !== 1'b0) begin
         bad++; $display("FAIL reset rst_auto: got %b want 0", rst_auto);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_hit();
      clear_stim();
      trg[10] = 1'b1;
      ph[10]  = 32'hFFFF0000;
      sp[10]  = 16'h000F;
      run_meas(31, 0, "single");
      total++;
      if (obs_d0 !== 15'd336 || obs_i0 !== 5'd4 || obs_n0 !== 2'd1 || obs_l0 !== 1'b1) begin
         bad++;
         $display("FAIL single_fields: got d=%0d i=%0d n=%0d l=%b want d=336 i=4 n=1 l=1",
                  obs_d0, obs_i0, obs_n0, obs_l0);
      end
   endtask

   task automatic test_overflow();
      clear_stim();
      trg[5]  = 1'b1;
      trg[20] = 1'b1;
      trg[40] = 1'b1;
      trg[60] = 1'b1;
      run_meas(100, 0, "overflow");
      total++;
      if (obs_beats != 3 || obs_n0 !== 2'd3 || obs_d0[14:5] !== 10'd5) begin
         bad++;
         $display("FAIL overflow_count: got beats=%0d n=%0d c0=%0d want 3 3 5",
                  obs_beats, obs_n0, obs_d0[14:5]);
      end
   endtask

   task automatic test_no_photon();
      clear_stim();
      run_meas(31, 0, "nophoton");
      total++;
      if (obs_d0 !== 15'h7FFF || obs_n0 !== 2'd0 || obs_l0 !== 1'b1) begin
         bad++;
         $display("FAIL nophoton_beat: got d=%h n=%0d l=%b want 7fff 0 1",
                  obs_d0, obs_n0, obs_l0);
      end
   endtask

   task automatic test_backpressure();
      clear_stim();
      trg[4]  = 1'b1;
      trg[12] = 1'b1;
      run_meas(31, 2, "backpressure");
      total++;
      if (obs_beats != 2 || obs_l0 !== 1'b0) begin
         bad++;
         $display("FAIL backpressure_beats: got %0d l0=%b want 2 0",
                  obs_beats, obs_l0);
      end
   endtask

   task automatic test_gating();
      clear_stim();
      trg[3]  = 1'b1;
      gate[3] = 1'b0;
      trg[8]  = 1'b1;
      ph[8]   = 32'h00000000;
      trg[10] = 1'b1;
      trg[20] = 1'b1;
      run_meas(31, 0, "gating");
      total++;
      if (obs_n0 !== 2'd2 || obs_d0 !== {10'd8, 5'd0}) begin
         bad++;
         $display("FAIL gating_fields: got n=%0d d=%h want n=2 d=%h",
                  obs_n0, obs_d0, {10'd8, 5'd0});
      end
   endtask

   task automatic test_range0();
      clear_stim();
      trg[0] = 1'b1;
      run_meas(0, 0, "range0");
      total++;
      if (obs_n0 !== 2'd1 || obs_d0[14:5] !== 10'd0) begin
         bad++;
         $display("FAIL range0_hit: got n=%0d c=%0d want 1 0",
                  obs_n0, obs_d0[14:5]);
      end
   endtask

   task automatic test_wrap();
      clear_stim();
      trg[1030] = 1'b1;
      run_meas(1100, 1, "wrap");
      total++;
      if (obs_d0[14:5] !== 10'd6) begin
         bad++;
         $display("FAIL wrap_coarse: got %0d want 6", obs_d0[14:5]);
      end
   endtask

   task automatic test_random();
      int r;
      int k;
      for (int it = 0; it < 12; it++) begin
         clear_stim();
         r = $urandom_range(0, 200);
         for (int j = 0; j <= r; j++) begin
            trg[j]  = ($urandom % 4) == 0;
            gate[j] = ($urandom % 5) != 0;
            k = $urandom_range(0, 3);
            if (k == 0)      ph[j] = 32'h0;
            else if (k == 1) ph[j] = 32'hFFFFFFFF;
            else if (k == 2) ph[j] = 32'h1 << $urandom_range(0, 31);
         end
         run_meas(r, 1, "random");
      end
   endtask

   task automatic test_reset_mid();
      clear_stim();
      trg[14] = 1'b1;
      rst         = 1'b0;
      TDC_start   = 1'b0;
      TDC_trigger = 1'b0;
      TDC_Range   = 15'd100;
      tick();
      TDC_start = 1'b1;
      tick();
      for (int j = 0; j < 15; j++) begin
         TDC_trigger = trg[j];
         TDC_tgate   = gate[j];
         DLL_Phase   = ph[j];
         TDC_spaden  = sp[j];
         tick();
      end
      total++;
      if (rst_auto !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_precap: got rst_auto=%b want 1", rst_auto);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid, TDC_INT, rst_auto} !== 27'd0) begin
         bad++;
         $display("FAIL rstmid_outputs: got d=%h i=%0d n=%0d l=%b v=%b int=%b ra=%b want all 0",
                  TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid, TDC_INT, rst_auto);
      end
      TDC_start   = 1'b0;
      TDC_trigger = 1'b0;
      tick();
      rst = 1'b0;
      for (int j = 0; j < 120; j++) begin
         tick();
         total++;
         if (TDC_Ovalid !== 1'b0 || TDC_INT !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_quiet cyc=%0d: got v=%b int=%b want 0 0",
                     j, TDC_Ovalid, TDC_INT);
         end
      end
      clear_stim();
      trg[2] = 1'b1;
      run_meas(20, 0, "rstmid_fresh");
      total++;
      if (obs_n0 !== 2'd1 || obs_d0[14:5] !== 10'd2) begin
         bad++;
         $display("FAIL rstmid_fresh: got n=%0d c=%0d want 1 2",
                  obs_n0, obs_d0[14:5]);
      end
   endtask

   initial begin
      rst         = 1'b1;
      DLL_Phase   = 32'h0;
      TDC_start   = 1'b0;
      TDC_trigger = 1'b0;
      TDC_tgate   = 1'b0;
      TDC_spaden  = 16'h0;
      TDC_Range   = 15'd0;
      TDC_Oready  = 1'b0;
      test_reset();
      test_single_hit();
      test_overflow();
      test_no_photon();
      test_backpressure();
      test_gating();
      test_range0();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
